// File: rtl/serial_byte_deserializer_if.sv
// Serial-in / parallel-out bus bundle for the bit-order test bus deserializer.
// The master side is the deserializer; the slave side is the bit source plus word consumer.
interface serial_byte_deserializer_if #(
    parameter int WIDTH = 8
);
    localparam int COUNT_W = $clog2(WIDTH + 1);

    logic               bit_in;
    logic               bit_valid;
    logic               frame_start;
    logic [WIDTH-1:0]   out_bus;
    logic               out_valid;
    logic               out_ready;
    logic [COUNT_W-1:0] bit_count;
    logic               overrun;

    modport master (
        input  bit_in,
        input  bit_valid,
        input  frame_start,
        input  out_ready,
        output out_bus,
        output out_valid,
        output bit_count,
        output overrun
    );

    modport slave (
        output bit_in,
        output bit_valid,
        output frame_start,
        output out_ready,
        input  out_bus,
        input  out_valid,
        input  bit_count,
        input  overrun
    );
endinterface

// File: rtl/serial_byte_deserializer.sv
// Collects a serial bit stream into WIDTH-bit words (MSB- or LSB-first) and offers each
// word through a single holding register with a valid/ready handshake.
module serial_byte_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_byte_deserializer_if.master  bus
);
    localparam int                 COUNT_W  = $clog2(WIDTH + 1);
    localparam logic [COUNT_W-1:0] LAST_BIT = COUNT_W'(WIDTH - 1);

    typedef enum logic {
        EMPTY,
        FULL
    } hold_state_t;

    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   shift_next;
    logic [WIDTH-1:0]   first_shift;
    logic [COUNT_W-1:0] count_q;
    logic [WIDTH-1:0]   hold_q;
    hold_state_t        hold_state;
    logic               overrun_q;
    logic               word_done;
    logic               accept_word;

    // first_shift is the register image after frame_start when a bit arrives on the same edge.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_next  = {shift_q[WIDTH-2:0], bus.bit_in};
            assign first_shift = {{(WIDTH-1){1'b0}}, bus.bit_in};
        end else begin : g_lsb_first
            assign shift_next  = {bus.bit_in, shift_q[WIDTH-1:1]};
            assign first_shift = {bus.bit_in, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    // frame_start wins over completion, so a word never completes on a realignment edge.
    assign word_done   = bus.bit_valid && !bus.frame_start && (count_q == LAST_BIT);
    assign accept_word = word_done && ((hold_state == EMPTY) || bus.out_ready);

    // NOTE: every register here uses non-blocking assignment so all state updates
    // from the same edge see pre-edge values, which back-to-back completion relies on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the holding register is a plain flop bank, not memory, so it is cleared
            // with everything else and out_bus reads 0 straight out of reset.
            shift_q    <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            hold_state <= EMPTY;
            overrun_q  <= 1'b0;
        end else begin
            if (bus.frame_start) begin
                count_q   <= bus.bit_valid ? COUNT_W'(1) : '0;
                shift_q   <= bus.bit_valid ? first_shift : '0;
                overrun_q <= 1'b0;
            end else if (bus.bit_valid) begin
                if (count_q == LAST_BIT) begin
                    count_q <= '0;
                    shift_q <= '0;
                end else begin
                    count_q <= count_q + COUNT_W'(1);
                    shift_q <= shift_next;
                end
            end

            if (word_done) begin
                if (accept_word) begin
                    hold_q     <= shift_next;
                    hold_state <= FULL;
                end else begin
                    overrun_q  <= 1'b1;
                end
            end else if ((hold_state == FULL) && bus.out_ready) begin
                hold_state <= EMPTY;
            end
        end
    end

    assign bus.out_bus   = hold_q;
    assign bus.out_valid = (hold_state == FULL);
    assign bus.bit_count = count_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Drives one stream into an MSB-first and an LSB-first deserializer and checks both
// against a bit-queue reference model plus a word scoreboard popped at each handshake.
module tb_serial_byte_deserializer;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_byte_deserializer_if #(.WIDTH(WIDTH)) bus_msb ();
    serial_byte_deserializer_if #(.WIDTH(WIDTH)) bus_lsb ();

    serial_byte_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_msb)
    );

    serial_byte_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_lsb)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: received bits of the partial word, holding-register occupancy,
    // sticky overrun, last presented word per bit order, and the expected word streams.
    bit         bits_q[$];
    bit         held;
    bit         ovr;
    logic [7:0] last_bus[2];
    logic [7:0] exp_msb[$];
    logic [7:0] exp_lsb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        bits_q.delete();
        held = 1'b0;
        ovr  = 1'b0;
        last_bus[0] = '0;
        last_bus[1] = '0;
        exp_msb.delete();
        exp_lsb.delete();
    endtask

    task automatic model_update(input bit bv, input bit b, input bit fs, input bit rdy);
        bit         done;
        logic [7:0] wm;
        logic [7:0] wl;
        done = 1'b0;
        wm   = '0;
        wl   = '0;
        if (fs) begin
            bits_q.delete();
            ovr = 1'b0;
            if (bv) bits_q.push_back(b);
        end else if (bv) begin
            bits_q.push_back(b);
            if (bits_q.size() == WIDTH) begin
                for (int i = 0; i < WIDTH; i++) begin
                    wm = wm + (8'(bits_q[i]) << (WIDTH - 1 - i));
                    wl = wl + (8'(bits_q[i]) << i);
                end
                done = 1'b1;
                bits_q.delete();
            end
        end
        if (done) begin
            if (held && !rdy) begin
                ovr = 1'b1;
            end else begin
                held        = 1'b1;
                last_bus[0] = wm;
                last_bus[1] = wl;
                exp_msb.push_back(wm);
                exp_lsb.push_back(wl);
            end
        end else if (held && rdy) begin
            held = 1'b0;
        end
    endtask

    task automatic drive(input bit bv, input bit b, input bit fs, input bit rdy);
        bus_msb.bit_valid = bv;  bus_lsb.bit_valid = bv;
        bus_msb.bit_in = b;      bus_lsb.bit_in = b;
        bus_msb.frame_start = fs; bus_lsb.frame_start = fs;
        bus_msb.out_ready = rdy; bus_lsb.out_ready = rdy;
    endtask

    task automatic check_outputs(input string name);
        check({name, "/msb valid"},   32'(bus_msb.out_valid), 32'(held));
        check({name, "/msb count"},   32'(bus_msb.bit_count), 32'(bits_q.size()));
        check({name, "/msb overrun"}, 32'(bus_msb.overrun),   32'(ovr));
        check({name, "/msb bus"},     32'(bus_msb.out_bus),   32'(last_bus[0]));
        check({name, "/lsb valid"},   32'(bus_lsb.out_valid), 32'(held));
        check({name, "/lsb count"},   32'(bus_lsb.bit_count), 32'(bits_q.size()));
        check({name, "/lsb overrun"}, 32'(bus_lsb.overrun),   32'(ovr));
        check({name, "/lsb bus"},     32'(bus_lsb.out_bus),   32'(last_bus[1]));
    endtask

    // Called at posedge+1 (or after reset release); drives, advances one edge, checks.
    task automatic step(input bit bv, input bit b, input bit fs, input bit rdy, input string name);
        drive(bv, b, fs, rdy);
        model_update(bv, b, fs, rdy);
        @(posedge clk);
        #1;
        check_outputs(name);
    endtask

    task automatic send_stream(input logic [7:0] pattern, input bit rdy, input bit rdy_last,
                               input string name);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, pattern[i], 1'b0, (i == 0) ? rdy_last : rdy, name);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "/msb bus"},   32'(bus_msb.out_bus),   32'h0);
        check({name, "/msb valid"}, 32'(bus_msb.out_valid), 32'h0);
        check({name, "/msb count"}, 32'(bus_msb.bit_count), 32'h0);
        check({name, "/msb ovr"},   32'(bus_msb.overrun),   32'h0);
        check({name, "/lsb bus"},   32'(bus_lsb.out_bus),   32'h0);
        check({name, "/lsb valid"}, 32'(bus_lsb.out_valid), 32'h0);
    endtask

    // Scoreboard monitor: a handshake is decided on the next rising edge, so sample at negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus_msb.out_valid && bus_msb.out_ready) begin
                if (exp_msb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard msb: unexpected word %0h, none expected", bus_msb.out_bus);
                end else begin
                    check("scoreboard msb word", 32'(bus_msb.out_bus), 32'(exp_msb.pop_front()));
                end
            end
            if (rst_n && bus_lsb.out_valid && bus_lsb.out_ready) begin
                if (exp_lsb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard lsb: unexpected word %0h, none expected", bus_lsb.out_bus);
                end else begin
                    check("scoreboard lsb word", 32'(bus_lsb.out_bus), 32'(exp_lsb.pop_front()));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_clear();
        #1;
        check_all_zero("reset");
        #11;
        rst_n = 1'b1;

        // Basic word with the consumer always ready; 0xC1 MSB-first, 0x83 LSB-first.
        send_stream(8'hC1, 1'b1, 1'b1, "c1");
        check("c1 msb word", 32'(bus_msb.out_bus), 32'hC1);
        check("c1 lsb word", 32'(bus_lsb.out_bus), 32'h83);
        step(1'b0, 1'b0, 1'b0, 1'b1, "c1 drain");

        // Overrun: 0x3C completes while 0xC1 is still held.
        send_stream(8'hC1, 1'b0, 1'b0, "ovr first");
        send_stream(8'h3C, 1'b0, 1'b0, "ovr second");
        check("ovr held msb", 32'(bus_msb.out_bus), 32'hC1);
        check("ovr flag", 32'(bus_msb.overrun), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "ovr consume");
        step(1'b0, 1'b0, 1'b0, 1'b1, "ovr idle");

        // frame_start with a bit on the same edge restarts the word and clears overrun.
        for (int i = 0; i < 5; i++) step(1'b1, 1'(i & 1), 1'b0, 1'b1, "fs partial");
        step(1'b1, 1'b1, 1'b1, 1'b1, "fs edge");
        check("fs count", 32'(bus_msb.bit_count), 32'h1);
        check("fs overrun cleared", 32'(bus_msb.overrun), 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1, "fs tail");
        step(1'b1, 1'b1, 1'b0, 1'b1, "fs last");
        check("fs msb word", 32'(bus_msb.out_bus), 32'h81);
        step(1'b0, 1'b0, 1'b0, 1'b1, "fs drain");

        // Consume and reload on the same edge: 0xA5 held, ready rises with 0x5A's last bit.
        send_stream(8'hA5, 1'b0, 1'b0, "swap first");
        send_stream(8'h5A, 1'b0, 1'b1, "swap second");
        check("swap msb word", 32'(bus_msb.out_bus), 32'h5A);
        check("swap valid", 32'(bus_msb.out_valid), 32'h1);
        check("swap overrun", 32'(bus_msb.overrun), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, "swap drain");

        // Asynchronous reset mid-cycle with a held word and a partial word of 4 bits.
        send_stream(8'hA5, 1'b0, 1'b0, "rst hold");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "rst partial");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        model_clear();
        #4;
        rst_n = 1'b1;
        send_stream(8'h96, 1'b1, 1'b1, "post reset");
        check("post reset msb word", 32'(bus_msb.out_bus), 32'h96);
        step(1'b0, 1'b0, 1'b0, 1'b1, "post reset drain");

        // Randomized traffic: gaps, occasional realignment, random back-pressure.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 39) == 0,
                 1'($urandom), "random");
        end
        for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, 1'b1, "final drain");
        check("scoreboard msb empty", 32'(exp_msb.size()), 32'h0);
        check("scoreboard lsb empty", 32'(exp_lsb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
